jtframe_irq_wdog: RTL

- Parametrised interrupt and watchdog controller for multi-CPU arcade boards.
- Merges N edge-triggered interrupt channels into one block. Each channel is either a latched line held until the CPU acknowledges it, or a timed pulse line.
- Adds a frame-counting watchdog with a programmable limit and a stretched CPU reset output.
- Sits between video timing (VBL, MCU port strobes) and the Z80/6801 interrupt and reset pins.

---
 rtl/jtframe_irq_wdog.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/jtframe_irq_wdog.sv
// jtframe_irq_wdog
// Interrupt merger and frame watchdog for multi-CPU arcade boards.
//
// Each of the CH interrupt channels watches a rising edge on sigedge. A
// channel runs in one of two modes:
//   latched - the line stays asserted until the CPU acknowledges it.
//   pulse   - the line stays asserted for 2^PW cen ticks.
// The watchdog counts rising edges of wdog_tick. When the count reaches
// wdog_limit, it pulls wdog_rst_n low for RSTLEN clk cycles.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   cen           clock enable, used only for pulse-width counting
//   sigedge[CH]   interrupt sources, rising-edge sensitive
//   mask[CH]      1 lets new edges in (never clears a pending request)
//   mode[CH]      0 = latched until ack, 1 = timed pulse
//   ack[CH]       level acknowledge, sampled every clk
//   irq_n[CH]     active-low interrupt lines
//   lost[CH]      sticky: an edge arrived while the latched line was pending
//   wdog_tick     watchdog count source, rising-edge sensitive
//   wdog_clr      watchdog kick, level
//   wdog_limit    fire threshold, 0 disables the watchdog
//   wdog_cnt      current watchdog count
//   wdog_rst_n    active-low CPU reset, stretched to RSTLEN clk cycles
//   wdog_fired    sticky: the watchdog has fired since reset

module jtframe_irq_wdog #(
   parameter int CH     = 4,
   parameter int PW     = 4,
   parameter int WDW    = 8,
   parameter int RSTLEN = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cen,
   input  logic [CH-1:0]  sigedge,
   input  logic [CH-1:0]  mask,
   input  logic [CH-1:0]  mode,
   input  logic [CH-1:0]  ack,
   output logic [CH-1:0]  irq_n,
   output logic [CH-1:0]  lost,
   input  logic           wdog_tick,
   input  logic           wdog_clr,
   input  logic [WDW-1:0] wdog_limit,
   output logic [WDW-1:0] wdog_cnt,
   output logic           wdog_rst_n,
   output logic           wdog_fired
);

   localparam int HW = $clog2(RSTLEN + 1);

   logic [CH-1:0] hist;
   logic [CH-1:0] pending;
   logic [CH-1:0] sig_edge;
   logic [PW-1:0] pcnt [CH];

   logic          tick_hist;
   logic          tick_edge;
   logic [HW-1:0] hold;
   logic          holding;
   logic          fire;

   // A masked channel ignores the edge completely. The history register
   // still follows the input, so unmasking while the input is high does
   // not create an event.
   always_comb begin
      sig_edge = sigedge & ~hist & mask;
   end

   // pending is a flop, so irq_n follows one clk after the edge cycle.
   assign irq_n = ~pending;

   // Per-channel request state. An edge always takes priority over ack,
   // so a new event in the acknowledge cycle is not lost. The pulse
   // counter only changes in pulse mode. If a channel switches modes,
   // it keeps its state and continues under the new rules.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist    <= '1;
         pending <= '0;
         lost    <= '0;
         for (int i = 0; i < CH; i++) begin
            pcnt[i] <= '0;
         end
      end else begin
         hist <= sigedge;
         for (int i = 0; i < CH; i++) begin
            if (!mode[i]) begin
               if (sig_edge[i]) begin
                  pending[i] <= 1'b1;
                  if (ack[i]) begin
                     lost[i] <= 1'b0;
                  end else if (pending[i]) begin
                     lost[i] <= 1'b1;
                  end
               end else if (ack[i]) begin
                  pending[i] <= 1'b0;
                  lost[i]    <= 1'b0;
               end
            end else begin
               if (sig_edge[i]) begin
                  pending[i] <= 1'b1;
                  pcnt[i]    <= '1;
               end else if (ack[i]) begin
                  pending[i] <= 1'b0;
               end else if (cen && pending[i]) begin
                  // One extra cen is spent at zero, so the line stays
                  // low for a full 2^PW ticks.
                  if (pcnt[i] == '0) begin
                     pending[i] <= 1'b0;
                  end else begin
                     pcnt[i] <= pcnt[i] - PW'(1);
                  end
               end
            end
         end
      end
   end

   // The watchdog cannot fire again while a reset hold is in progress.
   always_comb begin
      tick_edge = wdog_tick & ~tick_hist;
      holding   = (hold != '0);
      fire      = (wdog_limit != '0) && (wdog_cnt >= wdog_limit) && !holding;
   end

   // Watchdog counter and reset stretcher. hold counts down the remaining
   // low cycles. wdog_rst_n rises on the edge where hold goes from 1 to
   // 0, which gives exactly RSTLEN low cycles after the fire edge. Ticks
   // are ignored during the hold, and wdog_clr cannot shorten it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_hist  <= 1'b1;
         hold       <= '0;
         wdog_cnt   <= '0;
         wdog_rst_n <= 1'b0;
         wdog_fired <= 1'b0;
      end else begin
         tick_hist <= wdog_tick;
         if (fire) begin
            hold       <= HW'(RSTLEN);
            wdog_rst_n <= 1'b0;
            wdog_cnt   <= '0;
            wdog_fired <= 1'b1;
         end else if (holding) begin
            hold       <= hold - HW'(1);
            wdog_rst_n <= (hold == HW'(1));
            if (wdog_clr) begin
               wdog_cnt <= '0;
            end
         end else begin
            wdog_rst_n <= 1'b1;
            if (wdog_clr) begin
               wdog_cnt <= '0;
            end else if (tick_edge && (wdog_cnt != '1)) begin
               wdog_cnt <= wdog_cnt + WDW'(1);
            end
         end
      end
   end

endmodule
